// File: rtl/alu_result_stage.sv
`default_nettype none
// ============================================================================
// Module  : alu_result_stage
// Brief   : Registered ALU stage feeding the byte-wide 8:1 result mux, with a
//           2-entry skid buffer (main + skid) behind a registered in_ready.
// Revision: 1.0 - initial release
// ============================================================================
module alu_result_stage #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   results,
    output logic [2:0]           sel,
    output logic                 carry,
    output logic                 zero,
    output logic [15:0]          ops_done
);

    localparam int         NUM_OPS = 8;
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_NOT  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;
    localparam logic [2:0] OP_SHR  = 3'd7;

    typedef struct packed {
        logic [NUM_OPS-1:0][WIDTH-1:0] results;
        logic [2:0]                    sel;
        logic                          carry;
        logic                          zero;
    } entry_t;

    // ------------------------------------------------------------------
    // Parallel datapath: every slice is computed for every accept
    // ------------------------------------------------------------------
    logic [WIDTH:0]                sum_ext;
    logic [WIDTH:0]                diff_ext;
    logic [NUM_OPS-1:0][WIDTH-1:0] slices;
    logic [NUM_OPS-1:0]            slice_carry;
    logic [NUM_OPS-1:0]            slice_zero;
    entry_t                        new_entry;

    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};
    // Subtract as A + ~B + 1 so bit WIDTH is the "no borrow" carry.
    assign diff_ext = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        slices              = '0;
        slice_carry         = '0;
        slices[OP_ADD]      = sum_ext[WIDTH-1:0];
        slice_carry[OP_ADD] = sum_ext[WIDTH];
        slices[OP_SUB]      = diff_ext[WIDTH-1:0];
        slice_carry[OP_SUB] = diff_ext[WIDTH];
        slices[OP_AND]      = op_a & op_b;
        slices[OP_OR]       = op_a | op_b;
        slices[OP_XOR]      = op_a ^ op_b;
        slices[OP_NOT]      = ~op_a;
        slices[OP_SHL]      = {op_a[WIDTH-2:0], 1'b0};
        slice_carry[OP_SHL] = op_a[WIDTH-1];
        slices[OP_SHR]      = {1'b0, op_a[WIDTH-1:1]};
        slice_carry[OP_SHR] = op_a[0];
    end

    generate
        for (genvar k = 0; k < NUM_OPS; k++) begin : g_zero
            assign slice_zero[k] = ~|slices[k];
        end
    endgenerate

    always_comb begin
        new_entry         = '0;
        new_entry.results = slices;
        new_entry.sel     = opcode;
        new_entry.carry   = slice_carry[opcode];
        new_entry.zero    = slice_zero[opcode];
    end

    // ------------------------------------------------------------------
    // Main / skid storage
    // ------------------------------------------------------------------
    entry_t      main_q;
    entry_t      skid_q;
    logic        main_valid_q;
    logic        skid_valid_q;
    logic        in_ready_q;
    logic [15:0] ops_done_q;

    logic accept;
    logic emit;

    assign accept = in_valid && in_ready_q;
    assign emit   = main_valid_q && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            ops_done_q   <= '0;
        end else begin
            if (emit) begin
                ops_done_q <= ops_done_q + 16'd1;
            end

            if (skid_valid_q) begin
                // in_ready is low here, so no accept can collide with the refill.
                if (emit) begin
                    main_q       <= skid_q;
                    skid_valid_q <= 1'b0;
                    in_ready_q   <= 1'b1;
                end
            end else if (accept) begin
                if (!main_valid_q || emit) begin
                    main_q       <= new_entry;
                    main_valid_q <= 1'b1;
                end else begin
                    skid_q       <= new_entry;
                    skid_valid_q <= 1'b1;
                    in_ready_q   <= 1'b0;
                end
            end else if (emit) begin
                main_valid_q <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign results   = main_q.results;
    assign sel       = main_q.sel;
    assign carry     = main_q.carry;
    assign zero      = main_q.zero;
    assign ops_done  = ops_done_q;

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered stage directly upstream of the byte-wide 8:1 result mux in the ALU.
- Accepts operand A, operand B and a 3-bit opcode through a valid/ready handshake.
- Computes all eight byte results in parallel and presents them as a packed 8x8 bus, with the opcode as the mux select, plus carry and zero flags.
- A 2-entry skid buffer gives full throughput with a registered in_ready.

Parameters:
- WIDTH, 8, operand/result width in bits; the downstream mux is byte-wide, so only 8 is supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream has an operation
- in_ready  output  1  stage can accept; registered
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- opcode  input  3  operation code
- out_valid  output  1  results/sel/flags valid
- out_ready  input  1  downstream consumes
- results  output  8*WIDTH  packed; slice k = result of opcode k, in[k] of the mux
- sel  output  3  latched opcode, drives mux select
- carry  output  1  carry flag of the selected op
- zero  output  1  1 when the selected result is 0
- ops_done  output  16  count of completed output transfers

Behaviour:
- One clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - out_valid=0, in_ready=1, results=0, sel=0, carry=0, zero=0, ops_done=0.
  - Skid entry invalid.
  - Reset overrides any transfer in the same cycle.
  - Reset mid-operation discards both entries without producing an output transfer.
- Accept: in_valid && in_ready at an edge. Emit: out_valid && out_ready at an edge.
- Opcode map, slice k of results:
  - 0 ADD: A+B, carry = bit 8 of the 9-bit sum.
  - 1 SUB: A+~B+1, carry = bit 8 (1 = no borrow).
  - 2 AND: A&B, carry=0.
  - 3 OR: A|B, carry=0.
  - 4 XOR: A^B, carry=0.
  - 5 NOT: ~A, carry=0.
  - 6 SHL: A<<1, 0 shifted in, carry=A[7].
  - 7 SHR: A>>1 logical, 0 shifted in, carry=A[0].
- All eight slices are computed and stored every accept, regardless of opcode.
- carry and zero are computed for the opcode's own slice and stored with the entry.
- Result arithmetic is modulo 256; carry is the only overflow indication.
- Latency: an op accepted at edge N appears on the outputs after edge N (out_valid=1 in cycle N+1) when the output register is empty or draining.
- Output register (main entry):
  - Loads on accept when it is empty, or when it emits in the same cycle.
  - If it is holding (out_valid && !out_ready) when an accept occurs, the op goes to the skid entry instead.
- Skid entry:
  - Occupied means in_ready=0 from the next cycle.
  - On the next emit, the skid entry moves to main, the skid is cleared and in_ready returns to 1.
- Simultaneous accept and emit with the skid empty: main reloads with the new op; out_valid stays 1.
- Accept cannot occur while the skid is full, because in_ready=0.
- Stability: while out_valid && !out_ready, results, sel, carry and zero hold constant.
- in_ready depends only on registers, never combinationally on out_ready.
- Throughput: 1 op/cycle sustained when out_ready stays 1.
- ops_done increments by 1 on each emit and wraps 0xFFFF -> 0x0000.
- Outputs are don't-care while out_valid=0 but keep their last values. No X on outputs after reset.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, ops_done=0; results all 0 and sel=0, with nothing accepted.
- Single ADD, out_ready=1: A=0xF0, B=0x20, opcode=0 -> next cycle out_valid=1, sel=0, results[0]=0x10, carry=1, zero=0, results[1]=0xD0, results[2]=0x20, results[6]=0xE0, results[7]=0x78.
- SUB boundaries:
  - A=0x05, B=0x05, op 1 -> results[1]=0x00, carry=1, zero=1.
  - A=0x03, B=0x05 -> results[1]=0xFE, carry=0.
- Shifts: A=0x81, op 6 -> results[6]=0x02, carry=1; op 7 -> results[7]=0x40, carry=1.
- Backpressure: stream 4 ops with out_ready=0 -> op0 held in main, op1 in the skid, in_ready=0 from the cycle after op1 is accepted, op2 held upstream. Raise out_ready -> ops emitted in order 0,1,2,3, no loss or duplication, ops_done=4.
- Back-to-back plus wrap: preload ops_done to 0xFFFE through 0xFFFE transfers (or force), then stream 3 ops with out_ready=1 -> one emit per cycle, in_ready stays 1, ops_done reads 0xFFFF, 0x0000, 0x0001. Then assert reset while the skid is full -> all state cleared, no emit.
